tr_reg: RTL and testbench

TR_REG -- requirements
Module: tr_reg

---
 rtl/tr_pkg.sv | 20 ++
 rtl/tr_reg.sv | 48 ++++
 tb/tb_tr_reg.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tr_pkg.sv
// Shared width defaults and the zero-extension helper for the tr_reg transfer register.
package tr_pkg;

  localparam int TR_DIN_W  = 9;
  localparam int TR_DOUT_W = 18;
  // Widest DOUT_W the helper can extend to.
  localparam int TR_MAX_W  = 64;

  // Clears every bit at or above position w, so that only the low w bits of d survive.
  function automatic logic [TR_MAX_W-1:0] tr_zext(input logic [TR_MAX_W-1:0] d,
                                                  input int unsigned w);
    logic [TR_MAX_W-1:0] r;
    r = d;
    for (int i = 0; i < TR_MAX_W; i++) begin
      if (i >= int'(w)) r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/tr_reg.sv
// Transfer register: write loads tr_q with zero-extended din; read copies tr_q to dout one edge later.
// There is no backpressure, and each write overwrites tr_q. Define TR_BYPASS_EN for write-through when read and write are both set.
module tr_reg
  import tr_pkg::*;
#(
  parameter int DIN_W  = TR_DIN_W,
  parameter int DOUT_W = TR_DOUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic              read,
  input  logic [DIN_W-1:0]  din,
  output logic [DOUT_W-1:0] dout
);

  generate
    if (DOUT_W < DIN_W) begin : g_bad_width
      $error("tr_reg: DOUT_W must be >= DIN_W");
    end
    if (DOUT_W > TR_MAX_W) begin : g_too_wide
      $error("tr_reg: DOUT_W exceeds TR_MAX_W");
    end
  endgenerate

  logic [DOUT_W-1:0] tr_q;
  logic [DOUT_W-1:0] din_ext;

  assign din_ext = DOUT_W'(tr_zext(TR_MAX_W'(din), DIN_W));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tr_q <= '0;
      dout <= '0;
    end else begin
      if (write) tr_q <= din_ext;
      if (read) begin
`ifdef TR_BYPASS_EN
        dout <= write ? din_ext : tr_q;
`else
        // Read-before-write: on a shared edge, dout gets the value tr_q held before the write.
        dout <= tr_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_tr_reg.sv
// Directed checks of tr_reg in either build (with or without TR_BYPASS_EN).
module tb_tr_reg;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic        read;
  logic [8:0]  din;
  logic [17:0] dout;

  int checks = 0;
  int errors = 0;

  tr_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .write (write),
    .read  (read),
    .din   (din),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%05h expected 0x%05h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [17:0] sim_exp;

    // Reset held for two edges while read and write are both active.
    rst_n = 1'b0; write = 1'b1; read = 1'b1; din = 9'h1FF;
    step();
    step();
    check("rst_dout", dout, 18'h00000);
    check("rst_trq", dut.tr_q, 18'h00000);
    rst_n = 1'b1; write = 1'b0; read = 1'b0;
    step();
    check("rel_dout", dout, 18'h00000);
    check("rel_trq", dut.tr_q, 18'h00000);

    // Write, then read.
    write = 1'b1; din = 9'h00B;
    step();
    check("wr_trq", dut.tr_q, 18'h0000B);
    check("wr_dout_unchanged", dout, 18'h00000);
    write = 1'b0; read = 1'b1;
    step();
    check("rd_dout", dout, 18'h0000B);

    // Read and write on the same edge.
    write = 1'b1; read = 1'b1; din = 9'h00F;
`ifdef TR_BYPASS_EN
    sim_exp = 18'h0000F;
`else
    sim_exp = 18'h0000B;
`endif
    step();
    check("sim_dout", dout, sim_exp);
    check("sim_trq", dut.tr_q, 18'h0000F);
    write = 1'b0; read = 1'b1;
    step();
    check("sim_next_dout", dout, 18'h0000F);

    // Hold for five edges; din toggles, including between edges.
    write = 1'b0; read = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = 9'h155;
      #2 din = 9'h0AA;
      step();
      check("hold_dout", dout, 18'h0000F);
      check("hold_trq", dut.tr_q, 18'h0000F);
    end

    // Zero extension of an all-ones din.
    write = 1'b1; din = 9'h1FF;
    step();
    write = 1'b0; read = 1'b1;
    step();
    check("zext_dout", dout, 18'h001FF);

    // A write with read low leaves dout alone.
    write = 1'b1; read = 1'b0; din = 9'h123;
    step();
    check("wr_only_dout", dout, 18'h001FF);
    check("wr_only_trq", dut.tr_q, 18'h00123);

    // Back-to-back writes each overwrite tr_q.
    din = 9'h001;
    step();
    check("b2b_1", dut.tr_q, 18'h00001);
    din = 9'h002;
    step();
    check("b2b_2", dut.tr_q, 18'h00002);
    din = 9'h003;
    step();
    check("b2b_3", dut.tr_q, 18'h00003);

    // Mid-operation reset with read and write both active.
    rst_n = 1'b0; write = 1'b1; read = 1'b1; din = 9'h0AB;
    step();
    check("mid_rst_dout", dout, 18'h00000);
    check("mid_rst_trq", dut.tr_q, 18'h00000);

    // Read and write on the first edge after reset release are honoured.
    rst_n = 1'b1; write = 1'b1; read = 1'b1; din = 9'h05A;
`ifdef TR_BYPASS_EN
    sim_exp = 18'h0005A;
`else
    sim_exp = 18'h00000;
`endif
    step();
    check("post_rst_trq", dut.tr_q, 18'h0005A);
    check("post_rst_dout", dout, sim_exp);
    write = 1'b0; read = 1'b1;
    step();
    check("post_rst_rd", dout, 18'h0005A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
